// File: rtl/lsu_pkg.sv
// lsu_pkg: size/state enums plus size normalisation and low-address alignment helpers
package lsu_pkg;
  typedef enum logic [1:0] {LSU_SIZE_B = 2'b00, LSU_SIZE_H = 2'b01, LSU_SIZE_W = 2'b10} lsu_size_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;
  function automatic lsu_size_t norm_size(input logic [1:0] s);
    return s == 2'b00 ? LSU_SIZE_B : s == 2'b01 ? LSU_SIZE_H : LSU_SIZE_W;
  endfunction
  function automatic logic [1:0] align_lo(input lsu_size_t s, input logic [1:0] a);
    return s == LSU_SIZE_B ? a : s == LSU_SIZE_H ? {a[1], 1'b0} : 2'b00;
  endfunction
endpackage

// File: rtl/lsu_fmt.sv
// lsu_fmt: combinational byte enables, store lane replication (size/lo/wdata -> be/bus_wdata) and load extract/extend (rdata -> ldata)
module lsu_fmt
  import lsu_pkg::*;
(
  input  lsu_size_t   size,
  input  logic [1:0]  lo,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] bus_wdata,
  output logic [31:0] ldata
);
  logic [31:0] sh;
  always_comb begin
    be = size == LSU_SIZE_B ? 4'b0001 << lo : size == LSU_SIZE_H ? 4'b0011 << {lo[1], 1'b0} : 4'b1111;
    bus_wdata = size == LSU_SIZE_B ? {4{wdata[7:0]}} : size == LSU_SIZE_H ? {2{wdata[15:0]}} : wdata;
    sh = rdata >> {lo, 3'b000};
    ldata = size == LSU_SIZE_B ? {{24{~uns & sh[7]}}, sh[7:0]} :
            size == LSU_SIZE_H ? {{16{~uns & sh[15]}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store FSM; lsu_* EXU side, bus_* req/gnt/rvalid side; LSU_MISALIGN_TRAP_EN traps misaligned H/W without a bus access
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int TMO_CYCLES = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [1:0]      lsu_size_i,
  input  logic            lsu_uns_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_ready_o,
  output logic            lsu_done_o,
  output logic            lsu_err_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [3:0]      bus_be_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic            bus_gnt_i,
  input  logic            bus_rvalid_i,
  input  logic [XLEN-1:0] bus_rdata_i
);
  localparam int CW = $clog2(TMO_CYCLES);
  lsu_state_t state;
  lsu_size_t size_q, size_n;
  logic we_q, uns_q, misalign;
  logic [1:0] lo_q, lo_n;
  logic [XLEN-1:0] wdata_q, addr_q, ldata;
  logic [CW-1:0] cnt;
  logic [3:0] be;
  assign size_n = norm_size(lsu_size_i);
  assign lo_n = align_lo(size_n, lsu_addr_i[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = lo_n != lsu_addr_i[1:0];
`else
  assign misalign = 1'b0;
`endif
  lsu_fmt u_fmt (
    .size(size_q), .lo(lo_q), .uns(uns_q), .wdata(wdata_q), .rdata(bus_rdata_i),
    .be(be), .bus_wdata(bus_wdata_o), .ldata(ldata)
  );
  assign bus_we_o = we_q;
  assign bus_addr_o = addr_q;
  assign bus_be_o = bus_req_o ? be : 4'b0000;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      lsu_ready_o <= 1'b1;
      lsu_done_o <= 1'b0;
      lsu_err_o <= 1'b0;
      lsu_rdata_o <= '0;
      bus_req_o <= 1'b0;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= LSU_SIZE_B;
      lo_q <= 2'b00;
      wdata_q <= '0;
      addr_q <= '0;
      cnt <= '0;
    end else begin
      lsu_done_o <= 1'b0;
      case (state)
        IDLE: if (lsu_req_i) begin
          we_q <= lsu_we_i;
          uns_q <= lsu_uns_i;
          size_q <= size_n;
          lo_q <= lo_n;
          wdata_q <= lsu_wdata_i;
          addr_q <= {lsu_addr_i[XLEN-1:2], 2'b00};
          lsu_ready_o <= 1'b0;
          if (misalign) begin
            state <= DONE;
            lsu_done_o <= 1'b1;
            lsu_err_o <= 1'b1;
            lsu_rdata_o <= '0;
          end else begin
            state <= REQ;
            bus_req_o <= 1'b1;
          end
        end
        REQ: if (bus_gnt_i) begin
          state <= WAIT;
          bus_req_o <= 1'b0;
          cnt <= '0;
        end
        WAIT: if (bus_rvalid_i) begin
          state <= DONE;
          lsu_done_o <= 1'b1;
          lsu_err_o <= 1'b0;
          lsu_rdata_o <= ldata;
        end else if (cnt == CW'(TMO_CYCLES - 1)) begin
          state <= DONE;
          lsu_done_o <= 1'b1;
          lsu_err_o <= 1'b1;
          lsu_rdata_o <= '0;
        end else begin
          cnt <= cnt == '1 ? cnt : cnt + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          lsu_ready_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
